// File: rtl/nco_iq_mixer.sv
// Quadrature upconverter: holds baseband I/Q for SPS NCO samples and
// emits I*cos - Q*sin as a rounded, saturated offset-binary DAC code.
module nco_iq_mixer #(
  parameter int SPS = 4,
  parameter int W   = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clken,
  input  logic         nco_valid,
  input  logic [W-1:0] nco_sin,
  input  logic [W-1:0] nco_cos,
  input  logic [W-1:0] bb_i,
  input  logic [W-1:0] bb_q,
  input  logic         bb_valid,
  output logic         bb_ready,
  output logic [W-1:0] dac_data,
  output logic         dac_valid,
  output logic         underrun
);

  localparam int DW = 2 * W + 1;
  localparam logic [15:0] LAST = 16'(SPS - 1);
  localparam logic signed [DW-1:0] RND = DW'(2 ** (W - 2));
  localparam logic signed [DW-1:0] SMAX = DW'(2 ** (W - 1) - 1);
  localparam logic signed [DW-1:0] SMIN = DW'(-(2 ** (W - 1)));

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [15:0]    cnt, cnt_nx;
  logic [W-1:0]   pend_i, pend_q;
  logic           pend_full;
  logic [W-1:0]   cur_i, cur_q, cur_i_nx, cur_q_nx;
  logic           tick, accept, avail, boundary;
  logic           load, under_nx;
  logic [W-1:0]   src_i, src_q;

  assign bb_ready = ~pend_full;
  assign accept   = bb_valid & ~pend_full;
  assign tick     = clken & nco_valid;
  assign avail    = pend_full | accept;
  assign boundary = (cnt == LAST);
  assign src_i    = pend_full ? pend_i : bb_i;
  assign src_q    = pend_full ? pend_q : bb_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cur_i_nx = cur_i;
    cur_q_nx = cur_q;
    load     = 1'b0;
    under_nx = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (avail) begin
            load     = 1'b1;
            cnt_nx   = '0;
            cur_i_nx = src_i;
            cur_q_nx = src_q;
            state_nx = RUN;
          end
        end
        RUN: begin
          if (!boundary) begin
            cnt_nx = cnt + 16'd1;
          end else if (avail) begin
            load     = 1'b1;
            cnt_nx   = '0;
            cur_i_nx = src_i;
            cur_q_nx = src_q;
          end else begin
            under_nx = 1'b1;
            cur_i_nx = '0;
            cur_q_nx = '0;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_i    <= '0;
      cur_q    <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cur_i    <= cur_i_nx;
      cur_q    <= cur_q_nx;
      underrun <= under_nx;
    end
  end

  // A bypass load consumes the offered symbol, so the buffer stays empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_full <= 1'b0;
      pend_i    <= '0;
      pend_q    <= '0;
    end else if (accept && !(load && !pend_full)) begin
      pend_full <= 1'b1;
      pend_i    <= bb_i;
      pend_q    <= bb_q;
    end else if (load && pend_full) begin
      pend_full <= 1'b0;
    end
  end

  logic                 v1, v2;
  logic signed [2*W-1:0] p_c, p_s;
  logic signed [DW-1:0]  d, r_full, r;
  logic [W-1:0]          s;

  assign d = {p_c[2*W-1], p_c} - {p_s[2*W-1], p_s};
  assign r_full = (d + RND) >>> (W - 1);

  always_comb begin
    s = r[W-1:0];
    if (r > SMAX) s = SMAX[W-1:0];
    else if (r < SMIN) s = SMIN[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      p_c       <= '0;
      p_s       <= '0;
      r         <= '0;
      dac_valid <= 1'b0;
      dac_data  <= {1'b1, {(W-1){1'b0}}};
    end else if (clken) begin
      v1  <= tick;
      p_c <= $signed({{W{cur_i[W-1]}}, cur_i})
           * $signed({{W{nco_cos[W-1]}}, nco_cos});
      p_s <= $signed({{W{cur_q[W-1]}}, cur_q})
           * $signed({{W{nco_sin[W-1]}}, nco_sin});
      v2  <= v1;
      r   <= r_full;
      dac_valid <= v2;
      if (v2) dac_data <= {~s[W-1], s[W-2:0]};
    end
  end

endmodule
